// File: rtl/reg_busy_scoreboard.sv
// Register busy-bit scoreboard for decode/issue: one flag per architectural register,
// set on accepted issue, cleared at writeback, with same-cycle writeback bypass on reads.
module reg_busy_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int SEL_W     = 5,
  parameter int WAW_CHECK = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                issue_en,
  input  logic                issue_rd_we,
  input  logic [SEL_W-1:0]    issue_rd,
  input  logic                rs_use,
  input  logic [SEL_W-1:0]    rs,
  input  logic                rt_use,
  input  logic [SEL_W-1:0]    rt,
  input  logic                wb_en,
  input  logic [SEL_W-1:0]    wb_rd,
  output logic [NUM_REGS-1:0] busy,
  output logic                rs_busy,
  output logic                rt_busy,
  output logic                stall,
  output logic [SEL_W:0]      pending_cnt
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [SEL_W:0]      cnt_q;
  logic                waw;
  logic                accept;
  logic                set_en;
  logic                clr_en;
  logic                cnt_inc;
  logic                cnt_dec;

  // A writeback landing this cycle frees the register for a reader in the same cycle.
  assign rs_busy = rs_use & busy_q[rs] & ~(wb_en & (wb_rd == rs));
  assign rt_busy = rt_use & busy_q[rt] & ~(wb_en & (wb_rd == rt));
  assign waw     = (WAW_CHECK != 0) & issue_rd_we & busy_q[issue_rd]
                 & ~(wb_en & (wb_rd == issue_rd));
  assign stall   = issue_en & (rs_busy | rt_busy | waw);
  assign accept  = issue_en & ~stall & ~flush;

  assign set_en  = accept & issue_rd_we & (issue_rd != '0);
  assign clr_en  = wb_en & (wb_rd != '0);

  assign cnt_inc = set_en & ~busy_q[issue_rd];
  assign cnt_dec = clr_en & busy_q[wb_rd] & ~(set_en & (issue_rd == wb_rd));

  // Clear is applied first so a set to the same index wins (new producer).
  always_comb begin
    busy_nxt = busy_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (clr_en && (wb_rd == SEL_W'(i)))    busy_nxt[i] = 1'b0;
      if (set_en && (issue_rd == SEL_W'(i))) busy_nxt[i] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_nxt;
      cnt_q  <= cnt_q + {{SEL_W{1'b0}}, cnt_inc} - {{SEL_W{1'b0}}, cnt_dec};
    end
  end

  assign busy        = busy_q;
  assign pending_cnt = cnt_q;

endmodule

// File: tb/tb_reg_busy_scoreboard.sv
// Self-checking bench for reg_busy_scoreboard: directed scenarios plus randomized
// traffic compared against an array-based reference model of the busy flags.
module tb_reg_busy_scoreboard;

  localparam int NUM_REGS  = 32;
  localparam int SEL_W     = 5;
  localparam int WAW_CHECK = 1;

  logic                clock = 1'b0;
  logic                reset;
  logic                flush;
  logic                issue_en;
  logic                issue_rd_we;
  logic [SEL_W-1:0]    issue_rd;
  logic                rs_use;
  logic [SEL_W-1:0]    rs;
  logic                rt_use;
  logic [SEL_W-1:0]    rt;
  logic                wb_en;
  logic [SEL_W-1:0]    wb_rd;
  logic [NUM_REGS-1:0] busy;
  logic                rs_busy;
  logic                rt_busy;
  logic                stall;
  logic [SEL_W:0]      pending_cnt;

  int n_vec = 0;
  int n_err = 0;

  bit model_busy[NUM_REGS];

  reg_busy_scoreboard #(.NUM_REGS(NUM_REGS), .SEL_W(SEL_W), .WAW_CHECK(WAW_CHECK)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .issue_en(issue_en), .issue_rd_we(issue_rd_we), .issue_rd(issue_rd),
    .rs_use(rs_use), .rs(rs), .rt_use(rt_use), .rt(rt),
    .wb_en(wb_en), .wb_rd(wb_rd),
    .busy(busy), .rs_busy(rs_busy), .rt_busy(rt_busy), .stall(stall),
    .pending_cnt(pending_cnt)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [NUM_REGS-1:0] model_vec();
    logic [NUM_REGS-1:0] v = '0;
    for (int i = 0; i < NUM_REGS; i++) v[i] = model_busy[i];
    return v;
  endfunction

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < NUM_REGS; i++) c += int'(model_busy[i]);
    return c;
  endfunction

  function automatic bit src_busy(input bit use_it, input int idx);
    return use_it && model_busy[idx] && !(wb_en && int'(wb_rd) == idx);
  endfunction

  function automatic bit model_stall();
    bit waw;
    waw = (WAW_CHECK != 0) && issue_rd_we && model_busy[int'(issue_rd)]
          && !(wb_en && wb_rd == issue_rd);
    return issue_en && (src_busy(rs_use, int'(rs)) || src_busy(rt_use, int'(rt)) || waw);
  endfunction

  task automatic drive(input bit ie, input bit we, input int rd,
                       input bit ru, input int rsi, input bit tu, input int rti,
                       input bit wbe, input int wbr, input bit fl);
    issue_en = ie; issue_rd_we = we; issue_rd = SEL_W'(rd);
    rs_use = ru; rs = SEL_W'(rsi); rt_use = tu; rt = SEL_W'(rti);
    wb_en = wbe; wb_rd = SEL_W'(wbr); flush = fl;
  endtask

  // Check the combinational outputs for the driven inputs against the model.
  task automatic apply_chk();
    #1;
    chk("rs_busy", rs_busy, src_busy(rs_use, int'(rs)));
    chk("rt_busy", rt_busy, src_busy(rt_use, int'(rt)));
    chk("stall", stall, model_stall());
  endtask

  // Advance one edge, update the model from the rules, then check registered state.
  task automatic tick();
    bit acc;
    acc = issue_en && !model_stall() && !flush;
    @(posedge clock);
    if (flush) begin
      for (int i = 0; i < NUM_REGS; i++) model_busy[i] = 1'b0;
    end else begin
      if (wb_en && wb_rd != 0) model_busy[int'(wb_rd)] = 1'b0;
      if (acc && issue_rd_we && issue_rd != 0) model_busy[int'(issue_rd)] = 1'b1;
    end
    #1;
    chk("busy", busy, model_vec());
    chk("pending_cnt", pending_cnt, model_count());
    chk("cnt_range", pending_cnt <= (NUM_REGS - 1), 1);
  endtask

  task automatic cyc(input bit ie, input bit we, input int rd,
                     input bit ru, input int rsi, input bit tu, input int rti,
                     input bit wbe, input int wbr, input bit fl);
    drive(ie, we, rd, ru, rsi, tu, rti, wbe, wbr, fl);
    apply_chk();
    tick();
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < NUM_REGS; i++) model_busy[i] = 1'b0;
    #22;
    chk("rst_busy", busy, 0);
    chk("rst_cnt", pending_cnt, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    // T1: build busy=0xF0 then reset between edges
    for (int r = 4; r < 8; r++) cyc(1, 1, r, 0, 0, 0, 0, 0, 0, 0);
    chk("t1_busy_pre", busy, 32'h0000_00F0);
    drive(1, 0, 0, 1, 4, 0, 0, 0, 0, 0);
    #2;
    reset = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) model_busy[i] = 1'b0;
    #1;
    chk("t1_busy", busy, 0);
    chk("t1_cnt", pending_cnt, 0);
    chk("t1_stall", stall, 0);
    #1 reset = 1'b0;
    @(posedge clock); #1;

    // T2: RAW hazard and writeback bypass
    cyc(1, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 6, 1, 5, 0, 0, 0, 0, 0);
    apply_chk();
    chk("t2_stall", stall, 1);
    tick();
    chk("t2_busy5", busy[5], 1);
    chk("t2_busy6", busy[6], 0);
    drive(1, 1, 6, 1, 5, 0, 0, 1, 5, 0);
    apply_chk();
    chk("t2_bypass", stall, 0);
    tick();
    chk("t2_acc", busy[6:5], 2'b10);

    // T3: set and clear on the same index in one edge
    cyc(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 7, 0, 0, 0, 0, 1, 7, 0);
    apply_chk();
    chk("t3_stall", stall, 0);
    tick();
    chk("t3_busy7", busy[7], 1);
    chk("t3_cnt", pending_cnt, 2);

    // T4: register 0 never becomes busy
    cyc(1, 0, 0, 0, 0, 0, 0, 1, 6, 1);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    apply_chk();
    chk("t4_stall", stall, 0);
    tick();
    chk("t4_busy", busy, 0);
    chk("t4_cnt", pending_cnt, 0);

    // T5: fill every register, then flush with a competing issue
    for (int r = 1; r < NUM_REGS; r++) cyc(1, 1, r, 0, 0, 0, 0, 0, 0, 0);
    chk("t5_full", busy, 32'hFFFF_FFFE);
    chk("t5_cnt", pending_cnt, 31);
    cyc(1, 1, 3, 0, 0, 0, 0, 0, 0, 1);
    chk("t5_flush", busy, 0);
    chk("t5_flush_cnt", pending_cnt, 0);

    // T6: randomized traffic against the model
    for (int n = 0; n < 10000; n++) begin
      cyc($urandom_range(3) != 0, $urandom_range(3) != 0, $urandom_range(31),
          $urandom_range(1), $urandom_range(31), $urandom_range(1), $urandom_range(31),
          $urandom_range(1), $urandom_range(31), $urandom_range(127) == 0);
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
